// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU-side load/store initiator for a word-addressed data memory
// (combinational read, write on the clk negedge while mem_WE=1).
// Byte/half/word requests on byte addresses; sub-word stores use read-modify-write.
// Optional build macro: MEM_ACCESS_MISALIGN_TRAP_EN adds the err output and traps
// misaligned or reserved-size requests instead of silently aligning them.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_WE,
  input  logic [DATA_W-1:0] mem_data_out
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  ,
  output logic              err
`endif
);

  localparam int unsigned SIZE_W = 2;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_data_in_q, mem_data_in_d;
  logic                op_we_q, op_we_d;
  logic [SIZE_W-1:0]   op_size_q, op_size_d;
  logic                op_signed_q, op_signed_d;
  logic [LANE_W-1:0]   op_lane_q, op_lane_d;
  logic [HALF_W-1:0]   op_wdata_q, op_wdata_d;

  // Pick the addressed lane(s) out of a memory word and extend to a full word.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [SIZE_W-1:0] size,
                                                    input logic              sgn,
                                                    input logic [LANE_W-1:0] lane);
    logic [7:0]        b;
    logic [HALF_W-1:0] h;
    logic [DATA_W-1:0] res;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? HALF_W'(word >> 16) : HALF_W'(word);
    case (size)
      2'b00:   res = sgn ? DATA_W'({{24{b[7]}}, b}) : DATA_W'(b);
      2'b01:   res = sgn ? DATA_W'({{16{h[15]}}, h}) : DATA_W'(h);
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed byte/half lanes of the old word with store data.
  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] old_word,
                                                    input logic [HALF_W-1:0] wdata,
                                                    input logic [SIZE_W-1:0] size,
                                                    input logic [LANE_W-1:0] lane);
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] ins;
    mask = '0;
    ins  = '0;
    case (size)
      2'b00: begin
        mask = DATA_W'(32'h0000_00FF) << {lane, 3'b000};
        ins  = DATA_W'(wdata[7:0]) << {lane, 3'b000};
      end
      2'b01: begin
        mask = lane[1] ? DATA_W'(32'hFFFF_0000) : DATA_W'(32'h0000_FFFF);
        ins  = lane[1] ? DATA_W'({wdata, 16'h0000}) : DATA_W'(wdata);
      end
      default: begin
        mask = '0;
        ins  = '0;
      end
    endcase
    return (old_word & ~mask) | (ins & mask);
  endfunction

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  // Reserved size, or a half/word whose low address bits are not aligned.
  function automatic logic misaligned(input logic [SIZE_W-1:0] size,
                                      input logic [LANE_W-1:0] lane);
    return (size == 2'b11) ||
           ((size == 2'b01) && lane[0]) ||
           ((size == 2'b10) && (lane != 2'b00));
  endfunction
`endif

  // Next-state, request latching, memory drive and result computation.
  always_comb begin
    state_d       = state_q;
    rdata_d       = rdata_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    op_we_d       = op_we_q;
    op_size_d     = op_size_q;
    op_signed_d   = op_signed_q;
    op_lane_d     = op_lane_q;
    op_wdata_d    = op_wdata_q;
    err_d         = 1'b0;
    ready_d       = 1'b0;
    done_d        = 1'b0;
    mem_we_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req && ready_q) begin
          op_we_d       = req_we;
          op_size_d     = req_size;
          op_signed_d   = req_signed;
          op_lane_d     = req_addr[LANE_W-1:0];
          op_wdata_d    = req_wdata[HALF_W-1:0];
          mem_address_d = {2'b00, req_addr[ADDR_W-1:2]};
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
          if (misaligned(req_size, req_addr[LANE_W-1:0])) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else
`endif
          if (!req_we) begin
            state_d = S_READ;
          end else if (req_size[1]) begin
            // Word store (size 11 treated as word) skips the read.
            state_d       = S_WRITE;
            mem_data_in_d = req_wdata;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (op_we_q) begin
          mem_data_in_d = store_merge(mem_data_out, op_wdata_q, op_size_q, op_lane_q);
          state_d       = S_WRITE;
        end else begin
          rdata_d = load_extend(mem_data_out, op_size_q, op_signed_q, op_lane_q);
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of the state being entered.
    ready_d  = (state_d == S_IDLE);
    done_d   = (state_d == S_DONE);
    mem_we_d = (state_d == S_WRITE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ready_q       <= 1'b1;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      mem_we_q      <= 1'b0;
      rdata_q       <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      op_we_q       <= 1'b0;
      op_size_q     <= '0;
      op_signed_q   <= 1'b0;
      op_lane_q     <= '0;
      op_wdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      done_q        <= done_d;
      err_q         <= err_d;
      mem_we_q      <= mem_we_d;
      rdata_q       <= rdata_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      op_we_q       <= op_we_d;
      op_size_q     <= op_size_d;
      op_signed_q   <= op_signed_d;
      op_lane_q     <= op_lane_d;
      op_wdata_q    <= op_wdata_d;
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_WE      = mem_we_q;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign err         = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: word memory model plus a byte-addressed
// reference model; honours MEM_ACCESS_MISALIGN_TRAP_EN when defined.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_WE;
  logic [31:0] mem_data_out;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic        err;
`endif

  mem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .ready        (ready),
    .done         (done),
    .rdata        (rdata),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_WE       (mem_WE),
    .mem_data_out (mem_data_out)
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    ,
    .err          (err)
`endif
  );

  always #5 clk = ~clk;

  // Data memory: 64 words, combinational read, write on negedge.
  logic [31:0] mem [0:63];
  assign mem_data_out = mem[mem_address[5:0]];
  always @(negedge clk) if (mem_WE === 1'b1) mem[mem_address[5:0]] <= mem_data_in;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  ref_mem [0:255];
  logic [31:0] last_rdata;
  logic [31:0] obs_rd;

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_trap(input logic [1:0] size, input logic [31:0] addr);
    return TRAP_EN && ((size == 2'b11) || (size == 2'b01 && addr[0]) ||
                       (size == 2'b10 && addr[1:0] != 2'b00));
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] addr);
    int n = nbytes(size);
    logic [31:0] base = addr & ~32'(n - 1);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[8'(base + 32'(i))]) << (8 * i));
    if (n < 4 && sgn && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata);
    int n = nbytes(size);
    logic [31:0] base = addr & ~32'(n - 1);
    for (int i = 0; i < n; i++) ref_mem[8'(base + 32'(i))] = 8'(wdata >> (8 * i));
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    logic [31:0] b = addr & ~32'd3;
    return {ref_mem[8'(b + 32'd3)], ref_mem[8'(b + 32'd2)],
            ref_mem[8'(b + 32'd1)], ref_mem[8'(b)]};
  endfunction

  // Issue one request (starting at a negedge) and check its whole transaction.
  task automatic run_op(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int exp_lat, exp_we, lat, wes, w;
    bit trap;
    logic [31:0] exp_rd, exp_word, wword;
    trap = model_trap(size, addr);
    if (trap) begin
      exp_lat = 1; exp_we = 0; exp_rd = last_rdata;
    end else if (!we) begin
      exp_lat = 2; exp_we = 0; exp_rd = model_load(size, sgn, addr);
    end else begin
      exp_lat = (nbytes(size) == 4) ? 2 : 3; exp_we = 1;
      model_store(size, addr, wdata); exp_rd = last_rdata;
    end
    exp_word = model_word(addr);
    w = 0;
    while (ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_wait: ready=%b required 1", ready); end
    req = 1'b1; req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req = 1'b0;
    if (!trap) begin
      checks++;
      if (mem_address !== (addr >> 2)) begin
        errors++; $display("FAIL mem_address @%h: got %h required %h", addr, mem_address, addr >> 2);
      end
    end
    lat = 0; wes = 0; wword = '0;
    for (int n = 1; n <= 8; n++) begin
      if (n > 1) @(negedge clk);
      if (mem_WE === 1'b1) begin wes++; wword = mem_data_in; end
      if (done === 1'b1) begin
        lat = n; obs_rd = rdata;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        checks++;
        if (err !== 1'(trap)) begin errors++; $display("FAIL err @%h: got %b required %b", addr, err, trap); end
`endif
        break;
      end
    end
    checks++;
    if (lat != exp_lat) begin errors++; $display("FAIL latency @%h we=%b size=%b: got %0d required %0d", addr, we, size, lat, exp_lat); end
    checks++;
    if (wes != exp_we) begin errors++; $display("FAIL we_cycles @%h: got %0d required %0d", addr, wes, exp_we); end
    if (we && !trap) begin
      checks++;
      if (wword !== exp_word) begin errors++; $display("FAIL write_word @%h: got %h required %h", addr, wword, exp_word); end
    end
    checks++;
    if (obs_rd !== exp_rd) begin errors++; $display("FAIL rdata @%h size=%b sgn=%b: got %h required %h", addr, size, sgn, obs_rd, exp_rd); end
    @(negedge clk);
    checks++;
    if ({ready, done} !== 2'b10) begin errors++; $display("FAIL post_done @%h: ready,done=%b required 10", addr, {ready, done}); end
    last_rdata = exp_rd;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ready, done, mem_WE} !== 3'b100) begin errors++; $display("FAIL reset_ctrl: ready,done,we=%b required 100", {ready, done, mem_WE}); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h required 0", rdata); end
    checks++;
    if (mem_address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h required 0", mem_address); end
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err); end
`endif
    rst_n = 1'b1;
    last_rdata = '0;
    obs_rd = '0;
    @(negedge clk);
  endtask

  task automatic test_fill;
    for (int w = 0; w < 64; w++) run_op(1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom());
  endtask

  task automatic test_spec_vectors;
    run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    checks++;
    if (mem[4] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_store: got %h required deadbeef", mem[4]); end
    run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++;
    if (obs_rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_load: got %h required deadbeef", obs_rd); end
    run_op(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA);
    checks++;
    if (mem[4] !== 32'hDEAD_AAEF) begin errors++; $display("FAIL byte_store: got %h required deadaaef", mem[4]); end
    run_op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    checks++;
    if (obs_rd !== 32'hFFFF_FFDE) begin errors++; $display("FAIL lb_signed: got %h required ffffffde", obs_rd); end
    run_op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    checks++;
    if (obs_rd !== 32'h0000_00DE) begin errors++; $display("FAIL lb_unsigned: got %h required 000000de", obs_rd); end
    run_op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    checks++;
    if (obs_rd !== 32'hFFFF_DEAD) begin errors++; $display("FAIL lh_signed: got %h required ffffdead", obs_rd); end
    run_op(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
    checks++;
    if (obs_rd !== (TRAP_EN ? 32'hFFFF_DEAD : 32'h0000_AAEF)) begin
      errors++; $display("FAIL lh_misaligned: got %h required %h", obs_rd, TRAP_EN ? 32'hFFFF_DEAD : 32'h0000_AAEF);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a_addr, b_addr, exp_a, addr_busy;
    logic [1:0]  a_size;
    logic        a_sgn;
    int          dones, gap, w;
    a_addr = {$urandom_range(0, 255)} & ~32'd3;
    a_size = 2'b10;
    a_sgn  = 1'b0;
    b_addr = 32'($urandom_range(0, 255));
    exp_a  = model_load(a_size, a_sgn, a_addr);
    w = 0;
    while (ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    req = 1'b1; req_we = 1'b0; req_size = a_size; req_signed = a_sgn; req_addr = a_addr; req_wdata = '0;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_addr = b_addr; req_wdata = 32'h0000_005A;
    dones = 0; gap = 0; addr_busy = '0;
    for (int n = 1; n <= 8; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 2) addr_busy = mem_address;
      if (done === 1'b1) begin dones++; obs_rd = rdata; end
      if (ready === 1'b1) begin gap = n; break; end
    end
    checks++;
    if (gap != 3) begin errors++; $display("FAIL b2b_ready_gap: got %0d required 3", gap); end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL b2b_done_count: got %0d required 1", dones); end
    checks++;
    if (addr_busy !== (a_addr >> 2)) begin errors++; $display("FAIL b2b_busy_addr: got %h required %h", addr_busy, a_addr >> 2); end
    checks++;
    if (obs_rd !== exp_a) begin errors++; $display("FAIL b2b_rdata: got %h required %h", obs_rd, exp_a); end
    last_rdata = exp_a;
    run_op(1'b1, 2'b00, 1'b0, b_addr, 32'h0000_005A);
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom(), $urandom());
    end
  endtask

  task automatic test_reset_mid_op;
    bit seen;
    // Reset while the sub-word store is in READ: the write never happens.
    req = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h21; req_wdata = 32'h55;
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({ready, done, mem_WE} !== 3'b100) begin errors++; $display("FAIL rst_read_ctrl: ready,done,we=%b required 100", {ready, done, mem_WE}); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL rst_read_rdata: got %h required 0", rdata); end
    seen = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (mem_WE === 1'b1 || done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rst_read_quiet: got activity required none"); end
    last_rdata = '0;
    // Reset while in WRITE: that cycle's negedge write still lands.
    req = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h30; req_wdata = 32'h1234_5678;
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (mem_WE !== 1'b1) begin errors++; $display("FAIL rst_write_we: got %b required 1", mem_WE); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_store(2'b10, 32'h30, 32'h1234_5678);
    checks++;
    if ({ready, done, mem_WE} !== 3'b100) begin errors++; $display("FAIL rst_write_ctrl: ready,done,we=%b required 100", {ready, done, mem_WE}); end
    checks++;
    if (mem[12] !== 32'h1234_5678) begin errors++; $display("FAIL rst_write_mem: got %h required 12345678", mem[12]); end
    @(negedge clk);
  endtask

  task automatic test_final_memory;
    for (int w = 0; w < 64; w++) begin
      checks++;
      if (mem[w] !== model_word(32'(w * 4))) begin
        errors++; $display("FAIL mem_word[%0d]: got %h required %h", w, mem[w], model_word(32'(w * 4)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_spec_vectors();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    test_final_memory();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
